// File: rtl/seq_div_pkg.sv
// ============================================================================
//  Module   : seq_div_pkg
//  Purpose  : Shared width constants, FSM state type and sign helper for the
//             sequential restoring divider.
//  Contents : WIDTH    - operand/result width (8)
//             CTRWIDTH - step counter width (4)
//             state_t  - IDLE / CALC / FIX / DONE
//             apply_sign() - conditional two's-complement negation
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_div_pkg;

    localparam int WIDTH    = 8;
    localparam int CTRWIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Returns -mag when neg is set, otherwise mag unchanged.
    function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                    input logic [WIDTH-1:0] mag);
        return neg ? (-mag) : mag;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_div_div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step. The partial
//             remainder is shifted left taking in the dividend MSB, the
//             divisor is trial-subtracted, and the result is restored when
//             negative. The quotient bit enters the dividend register LSB,
//             so after WIDTH steps that register holds the quotient.
//  Ports    : i_rem  - partial remainder in (always < divisor magnitude)
//             i_dvd  - dividend/quotient shift register in
//             i_dvs  - divisor magnitude
//             o_rem  - partial remainder out
//             o_dvd  - dividend/quotient shift register out
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import seq_div_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dvd
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_neg;

    // One extra bit so the trial subtraction can go negative.
    assign w_shift = {i_rem, i_dvd[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign w_neg   = w_diff[WIDTH];

    // Remainder stays below the divisor, so WIDTH bits always suffice.
    assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_dvd = {i_dvd[WIDTH-2:0], ~w_neg};

endmodule

`default_nettype wire

// File: rtl/seq_div.sv
// ============================================================================
//  Module   : seq_div
//  Purpose  : Fixed-latency sequential restoring divider. A start accepted
//             in IDLE or DONE loads the operands, WIDTH CALC cycles produce
//             the quotient/remainder magnitudes, and FIX applies signs and
//             publishes the result with rdy=1 on the 10th edge.
//  Build    : SEQ_DIV_SIGNED_EN defined   -> two's-complement operands
//             SEQ_DIV_SIGNED_EN undefined -> unsigned operands (default)
//  Ports    : clk   - clock, rising edge
//             reset - synchronous active-low reset
//             start - request a division (honoured in IDLE/DONE only)
//             a, b  - dividend, divisor
//             q, r  - registered quotient, remainder
//             rdy   - result valid
//             dbz   - divide-by-zero flag, valid with rdy
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div
    import seq_div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             rdy,
    output logic             dbz
);

    state_t              r_state;
    logic [CTRWIDTH-1:0] r_ctr;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_dvd;
    logic [WIDTH-1:0]    r_dvs;
    logic                r_sa;
    logic                r_sb;
    logic                r_bzero;

    logic                w_sa;
    logic                w_sb;
    logic [WIDTH-1:0]    w_amag;
    logic [WIDTH-1:0]    w_bmag;
    logic [WIDTH-1:0]    w_rem_nxt;
    logic [WIDTH-1:0]    w_dvd_nxt;

`ifdef SEQ_DIV_SIGNED_EN
    assign w_sa   = a[WIDTH-1];
    assign w_sb   = b[WIDTH-1];
    // -0x80 wraps back to 0x80, which is still the correct unsigned magnitude.
    assign w_amag = apply_sign(w_sa, a);
    assign w_bmag = apply_sign(w_sb, b);
`else
    assign w_sa   = 1'b0;
    assign w_sb   = 1'b0;
    assign w_amag = a;
    assign w_bmag = b;
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_dvd (w_dvd_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ctr   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bzero <= 1'b0;
            q       <= '0;
            r       <= '0;
            rdy     <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_dvd   <= w_amag;
                        r_dvs   <= w_bmag;
                        r_rem   <= '0;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_bzero <= (b == '0);
                        r_ctr   <= '0;
                        rdy     <= 1'b0;
                        dbz     <= 1'b0;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_dvd_nxt;
                    if (r_ctr == CTRWIDTH'(WIDTH-1)) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_ctr <= r_ctr + 1'b1;
                    end
                end
                ST_FIX: begin
                    // With a zero divisor the step loop leaves |a| in the
                    // remainder, so the sign fix-up restores r = a exactly.
                    q       <= r_bzero ? '1 : apply_sign(r_sa ^ r_sb, r_dvd);
                    r       <= apply_sign(r_sa, r_rem);
                    dbz     <= r_bzero;
                    rdy     <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Directed self-checking bench for seq_div. Expected values are
//             hand-computed; signed vectors apply when SEQ_DIV_SIGNED_EN is
//             defined, unsigned ones otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic [7:0] q;
    logic [7:0] r;
    logic       rdy;
    logic       dbz;

    int n_cmp = 0;
    int n_err = 0;

    seq_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .rdy   (rdy),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept on edge 1, rdy must stay low through edge 9 and rise on edge 10.
    task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] eq, input logic [7:0] er, input logic ed);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({tag, " rdy after accept"}, {7'd0, rdy}, 8'd0);
        check({tag, " dbz after accept"}, {7'd0, dbz}, 8'd0);
        tick(8);
        check({tag, " rdy at edge 9"}, {7'd0, rdy}, 8'd0);
        tick(1);
        check({tag, " rdy at edge 10"}, {7'd0, rdy}, 8'd1);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check({tag, " dbz"}, {7'd0, dbz}, {7'd0, ed});
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd1;
        tick(2);
        start = 1'b0;
        check("reset q", q, 8'h00);
        check("reset r", r, 8'h00);
        check("reset rdy", {7'd0, rdy}, 8'd0);
        check("reset dbz", {7'd0, dbz}, 8'd0);
        reset = 1'b1;
        tick(1);

        run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
        run_div("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
        run_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
`else
        run_div("156/7", 8'h9C, 8'd7, 8'd22, 8'd2, 1'b0);
        run_div("200/3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
`endif
        run_div("7/0", 8'd7, 8'd0, 8'hFF, 8'h07, 1'b1);

        // DONE holds its result while start stays low
        a = 8'd1;
        b = 8'd1;
        tick(3);
        check("hold q", q, 8'hFF);
        check("hold r", r, 8'h07);
        check("hold rdy", {7'd0, rdy}, 8'd1);
        check("hold dbz", {7'd0, dbz}, 8'd1);

        run_div("ff/ff", 8'hFF, 8'hFF, 8'd1, 8'd0, 1'b0);
        run_div("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);

        // start pulsed in CALC cycle 3 with new operands must be ignored
        a     = 8'd50;
        b     = 8'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        a     = 8'd9;
        b     = 8'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        tick(5);
        check("ignore rdy at edge 9", {7'd0, rdy}, 8'd0);
        tick(1);
        check("ignore rdy at edge 10", {7'd0, rdy}, 8'd1);
        check("ignore q", q, 8'd10);
        check("ignore r", r, 8'd0);
        check("ignore dbz", {7'd0, dbz}, 8'd0);

        // reset in CALC cycle 5 aborts; nothing completes afterwards
        a     = 8'd45;
        b     = 8'd6;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("abort q", q, 8'h00);
        check("abort r", r, 8'h00);
        check("abort rdy", {7'd0, rdy}, 8'd0);
        check("abort dbz", {7'd0, dbz}, 8'd0);
        tick(10);
        check("abort idle rdy", {7'd0, rdy}, 8'd0);
        check("abort idle q", q, 8'h00);

        run_div("45/6 after abort", 8'd45, 8'd6, 8'd7, 8'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
